// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file feeding the ALU operands. Writes sit in a
// one-entry pending register for a cycle before commit; reads forward around it.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Rd_Addr_1,
  input  logic [ADDR_W-1:0] Rd_Addr_2,
  output logic [DATA_W-1:0] Rd_Data_1,
  output logic [DATA_W-1:0] Rd_Data_2,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Pend_Valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              r_p_valid;
  logic [ADDR_W-1:0] r_p_addr;
  logic [DATA_W-1:0] r_p_data;

  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];

  // Old pending write commits on the same edge a new one is captured, so two
  // back-to-back writes to one address land in the array in issue order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_p_valid <= 1'b0;
      r_p_addr  <= '0;
      r_p_data  <= '0;
    end else begin
      if (r_p_valid) begin
        r_regs[r_p_addr] <= r_p_data;
      end
      r_p_valid <= Wr_En && (Wr_Addr != '0);
      r_p_addr  <= Wr_Addr;
      r_p_data  <= Wr_Data;
    end
  end

  assign w_rd_addr[0] = Rd_Addr_1;
  assign w_rd_addr[1] = Rd_Addr_2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      // Newest source wins: live write, then pending, then array.
      always_comb begin
        w_rd_data[gi] = r_regs[w_rd_addr[gi]];
        if (w_rd_addr[gi] == '0) begin
          w_rd_data[gi] = '0;
        end else if (Wr_En && (Wr_Addr == w_rd_addr[gi])) begin
          w_rd_data[gi] = Wr_Data;
        end else if (r_p_valid && (r_p_addr == w_rd_addr[gi])) begin
          w_rd_data[gi] = r_p_data;
        end
      end
    end
  endgenerate

  assign Rd_Data_1  = w_rd_data[0];
  assign Rd_Data_2  = w_rd_data[1];
  assign Pend_Valid = r_p_valid;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: an architectural model (a register
// returns its newest written value) predicts each cycle's reads.
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr_1, rd_addr_2, wr_addr;
  logic [DATA_W-1:0] rd_data_1, rd_data_2, wr_data;
  logic              wr_en, pend_valid;

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .Rd_Addr_1(rd_addr_1), .Rd_Addr_2(rd_addr_2),
    .Rd_Data_1(rd_data_1), .Rd_Data_2(rd_data_2),
    .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Pend_Valid(pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              pv;
    logic              has_alu;
    logic [DATA_W-1:0] res;
    logic              zf;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Architectural model: latest value per register, plus whether the
  // previous cycle accepted a write (which is what Pend_Valid shows).
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic              model_pend;

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a,
      input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return model_mem[a];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
      input logic has_alu = 1'b0, input logic [DATA_W-1:0] res = '0, input logic zf = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_1 = a1; rd_addr_2 = a2;
    e.rd1 = model_read(a1, we, wa, wd);
    e.rd2 = model_read(a2, we, wa, wd);
    e.pv = model_pend;
    e.has_alu = has_alu; e.res = res; e.zf = zf;
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_pend = 1'b0;
    end else begin
      if (we && wa != 0) model_mem[wa] = wd;
      model_pend = we && (wa != 0);
    end
  endtask

  // Monitor: outputs are settled by the falling edge of the cycle they were driven in.
  initial begin
    exp_t e;
    logic [DATA_W-1:0] alu_res;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rd_data_1 !== e.rd1) begin
          n_err++;
          $display("FAIL rd1 a=%0d got=%h exp=%h", rd_addr_1, rd_data_1, e.rd1);
        end
        n_vec++;
        if (rd_data_2 !== e.rd2) begin
          n_err++;
          $display("FAIL rd2 a=%0d got=%h exp=%h", rd_addr_2, rd_data_2, e.rd2);
        end
        n_vec++;
        if (pend_valid !== e.pv) begin
          n_err++;
          $display("FAIL pend_valid got=%b exp=%b", pend_valid, e.pv);
        end
        if (e.has_alu) begin
          alu_res = rd_data_1 - rd_data_2;
          n_vec++;
          if (alu_res !== e.res || (alu_res == 0) !== e.zf) begin
            n_err++;
            $display("FAIL alu_sub res=%h zf=%b exp res=%h zf=%b",
                     alu_res, (alu_res == 0), e.res, e.zf);
          end
        end
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] wa, a1, a2;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_pend = 1'b0;

    drive(1, 0, 0, 0, 0, 0);
    // Reset clear
    drive(0, 1, 5, 32'hDEADBEEF, 5, 9);
    drive(0, 1, 9, 32'h0000_1234, 5, 9);
    drive(0, 0, 0, 0, 5, 9);
    drive(0, 0, 0, 0, 5, 9);
    drive(1, 1, 5, 32'hCAFE_0000, 5, 9);
    drive(0, 0, 0, 0, 5, 9);
    // Write-through, pending, committed
    drive(0, 1, 7, 32'h0000_00AA, 7, 0);
    drive(0, 0, 0, 0, 7, 0);
    drive(0, 0, 0, 0, 7, 0);
    // Back-to-back same address
    drive(0, 1, 3, 32'h11, 0, 3);
    drive(0, 1, 3, 32'h22, 0, 3);
    drive(0, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 3, 3);
    // Register 0
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // Reset mid-operation
    drive(0, 1, 12, 32'h5555, 12, 12);
    drive(1, 0, 0, 0, 12, 12);
    drive(0, 0, 0, 0, 12, 12);
    drive(0, 0, 0, 0, 12, 31);
    // ALU hookup
    drive(0, 1, 4, 32'd10, 0, 0);
    drive(0, 1, 6, 32'd3, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 4, 6, 1'b1, 32'd7, 1'b0);
    drive(0, 0, 0, 0, 4, 4, 1'b1, 32'd0, 1'b1);
    // Highest address write and read-back
    drive(0, 1, 31, 32'hA5A5_5A5A, 31, 30);
    drive(0, 0, 0, 0, 31, 31);

    // Random phase: narrow address range half the time to force collisions
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        wa = ADDR_W'($urandom_range(0, 3));
        a1 = ADDR_W'($urandom_range(0, 3));
        a2 = ADDR_W'($urandom_range(0, 3));
      end else begin
        wa = ADDR_W'($urandom);
        a1 = ADDR_W'($urandom);
        a2 = ADDR_W'($urandom);
      end
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), wa,
            $urandom, a1, a2);
    end

    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Register file directly upstream of the ALU. Its two read ports drive the ALU operands Op_1 and Op_2.
- Write-back result (ALU Res, or memory data) enters through a single write port.
- Writes are buffered one cycle in a pending write-back register before commit to the array.
- Full forwarding hides that buffering from readers: a register read returns the newest value the moment it is written.

Parameters:
- DATA_W, 32, data width of each register and of all data ports.
- ADDR_W, 5, register address width; depth = 2**ADDR_W (32 registers).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Rd_Addr_1  in  ADDR_W  read port 1 address (rs).
- Rd_Addr_2  in  ADDR_W  read port 2 address (rt).
- Rd_Data_1  out  DATA_W  read port 1 data, to ALU Op_1.
- Rd_Data_2  out  DATA_W  read port 2 data, to ALU Op_2 (via immediate mux).
- Wr_En  in  1  write request this cycle.
- Wr_Addr  in  ADDR_W  write address (rd/rt).
- Wr_Data  in  DATA_W  write data.
- Pend_Valid  out  1  pending write-back register holds an uncommitted write (debug/verification visibility).

Behaviour:
- State:
  - Array regs[0..2**ADDR_W-1].
  - Pending register: P_Valid, P_Addr, P_Data.
- Reset (rst=1 at rising edge):
  - All array entries go to 0.
  - P_Valid goes to 0; P_Addr and P_Data go to 0.
  - A pending write present at reset is discarded, not committed.
  - A Wr_En asserted in the same cycle as rst is ignored.
- Write pipeline (rst=0), at each rising edge:
  - If P_Valid=1: regs[P_Addr] <= P_Data (commit).
  - Then P_Valid <= Wr_En & (Wr_Addr != 0); P_Addr <= Wr_Addr; P_Data <= Wr_Data.
  - Commit of the old pending write and capture of a new write happen on the same edge, including when both target the same address. The array receives the old value now and the newer value one edge later; the ordering is preserved.
- Register 0:
  - Hardwired to zero.
  - Writes to address 0 never set P_Valid and never modify the array.
  - Reads of address 0 return 0 regardless of any forwarding source.
- Read ports:
  - Purely combinational, zero latency, identical logic per port.
  - Priority for Rd_Data_n, highest first:
    1. Rd_Addr_n == 0 -> 0.
    2. Wr_En=1 and Wr_Addr == Rd_Addr_n -> Wr_Data (same-cycle write-through).
    3. P_Valid=1 and P_Addr == Rd_Addr_n -> P_Data.
    4. Otherwise regs[Rd_Addr_n].
  - Both ports may address the same register; both return the same value.
  - Read data during a cycle with rst=1 follows the same combinational rules against the pre-reset state. Values are only guaranteed 0 from the cycle after reset.
- Pend_Valid = P_Valid. Reset value 0.
- Width rules:
  - No arithmetic.
  - Addresses compared over the full ADDR_W bits.
  - Data passed unmodified at DATA_W bits.
- No stalls or backpressure: a write is accepted every cycle Wr_En=1.

Test Plan:
- Reset clear: preload regs 5=0xDEADBEEF, 9=0x1234; assert rst 1 cycle; release -> Rd_Addr_1=5, Rd_Addr_2=9 read 0x0 / 0x0, Pend_Valid=0.
- Write-through and commit: Wr_En=1, Wr_Addr=7, Wr_Data=0x0000_00AA with Rd_Addr_1=7.
  - Same cycle -> Rd_Data_1=0xAA.
  - Next cycle, Wr_En=0 -> Rd_Data_1=0xAA from pending, Pend_Valid=1.
  - Following cycle -> 0xAA from array, Pend_Valid=0.
- Back-to-back same address: write r3=0x11 in cycle N, r3=0x22 in cycle N+1, idle after.
  - Rd_Addr_2=3 reads 0x11 in N and 0x22 in N+1, N+2, N+3.
  - Array r3 ends at 0x22.
- Register 0: write Wr_Addr=0, Wr_Data=0xFFFFFFFF -> Rd_Data_1 with Rd_Addr_1=0 reads 0 in the same and all later cycles; Pend_Valid stays 0.
- Reset mid-operation: write r12=0x5555 in cycle N, assert rst in cycle N+1 -> r12 reads 0 after reset (pending write dropped); Pend_Valid=0.
- Dual-port same address plus ALU hookup: r4=10, r6=3 committed; Rd_Addr_1=4, Rd_Addr_2=6 into ALU with SUB (0110) -> Res=7, ZF=0. Rd_Addr_1=Rd_Addr_2=4 with SUB -> Res=0, ZF=1.
